// File: rtl/pll_reset_ctrl_if.sv
// Lock/reset bundle between the PLL reset controller and the PLL/system side.
// master is the controller; slave is the PLL plus downstream reset consumers.
interface pll_reset_ctrl_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] relock_count;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_reset_n,
        output ready,
        output lock_lost,
        output relock_count
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_reset_n,
        input  ready,
        input  lock_lost,
        input  relock_count
    );
endinterface

// File: rtl/pll_reset_ctrl.sv
// Sequences PLL reset and lock, releasing system reset only after lock has
// held steady; runs entirely on the free-running reference clock.
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             refclk,
    input  logic             rst_n,
    pll_reset_ctrl_if.master bus
);
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                           PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   armed_q;
    logic                   pll_rst_q;
    logic                   srst_n_q;
    logic                   ready_q;
    logic                   lost_q, lost_d;
    logic [7:0]             rc_q, rc_d;
    logic                   rc_inc;
    logic                   locked_s;

    // A PLL held in reset cannot be locked, so stale lock is flushed here.
    assign sync_d   = (state_q == RESET_PLL) ? '0 :
                      {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        lost_d  = 1'b0;
        rc_inc  = 1'b0;
        if (!armed_q) begin
            cnt_d = cnt_q;
        end else if (bus.relock_req) begin
            state_d = RESET_PLL;
            lost_d  = (state_q == RUN) && !locked_s;
            rc_inc  = 1'b1;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABILIZE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = RESET_PLL;
                        rc_inc  = 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) state_d = WAIT_LOCK;
                    else if (cnt_q == STB_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = RESET_PLL;
                        lost_d  = 1'b1;
                        rc_inc  = 1'b1;
                    end
                end
                default: state_d = RESET_PLL;
            endcase
        end
        // Fresh count on every entry, including a re-request inside RESET_PLL.
        if (state_d != state_q || (armed_q && bus.relock_req)) begin
            cnt_d = '0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q;
        end
        rc_d = (rc_inc && rc_q != 8'hFF) ? rc_q + 8'd1 : rc_q;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            sync_q    <= '0;
            armed_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            srst_n_q  <= 1'b0;
            ready_q   <= 1'b0;
            lost_q    <= 1'b0;
            rc_q      <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            armed_q   <= 1'b1;
            pll_rst_q <= (state_d == RESET_PLL);
            srst_n_q  <= (state_d == RUN);
            ready_q   <= (state_d == RUN);
            lost_q    <= lost_d;
            rc_q      <= rc_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_reset_n  = srst_n_q;
    assign bus.ready        = ready_q;
    assign bus.lock_lost    = lost_q;
    assign bus.relock_count = rc_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scenario bench for pll_reset_ctrl: expected values are queued when
// stimulus is applied and popped when the matching DUT event is observed.
module tb_pll_reset_ctrl;
    localparam int RSTC = 4;
    localparam int TMO  = 20;
    localparam int STB  = 8;
    localparam int SYN  = 2;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];

    pll_reset_ctrl_if bus();

    pll_reset_ctrl #(
        .PLL_RST_CYCLES(RSTC),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STB),
        .SYNC_STAGES   (SYN)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    task automatic step();
        @(negedge refclk);
    endtask

    task automatic apply_reset(input logic lk);
        rst_n          = 1'b0;
        bus.pll_locked = lk;
        bus.relock_req = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        logic [11:0] act;
        int          e;
        apply_reset(1'b1);
        exp_q.push_back('h800);
        act = {bus.pll_rst, bus.sys_reset_n, bus.ready,
               bus.lock_lost, bus.relock_count};
        e = exp_q.pop_front();
        checks++;
        if (act !== 12'(e)) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", act, 12'(e));
        end
    endtask

    task automatic test_startup();
        int hi  = 0;
        int lat = 0;
        int mis = 0;
        int e;
        exp_q.push_back(RSTC);
        exp_q.push_back(0);
        rst_n = 1'b1;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            step();
            if (bus.pll_rst) hi++;
            if (bus.ready !== bus.sys_reset_n) mis++;
            if (bus.sys_reset_n) lat = i;
        end
        e = exp_q.pop_front();
        checks++;
        if (hi !== e) begin
            errors++;
            $display("FAIL startup_pll_rst_width: got %0d expected %0d", hi, e);
        end
        checks++;
        if (lat < RSTC + SYN + STB + 2 || lat > RSTC + SYN + STB + 4) begin
            errors++;
            $display("FAIL startup_latency: got %0d expected 16..18", lat);
        end
        checks++;
        if (mis != 0) begin
            errors++;
            $display("FAIL startup_ready_tracks_srst: got %0d expected 0", mis);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e)) begin
            errors++;
            $display("FAIL startup_relock_count: got %0d expected %0d",
                     bus.relock_count, e);
        end
    endtask

    task automatic test_timeout();
        int   rises = 0;
        int   rise_at = -1;
        int   srst_bad = 0;
        int   e;
        logic last = 1'b1;
        apply_reset(1'b0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        rst_n = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (bus.sys_reset_n) srst_bad++;
            if (bus.pll_rst && !last && exp_q.size() > 0) begin
                rises++;
                e = exp_q.pop_front();
                checks++;
                if (bus.relock_count !== 8'(e)) begin
                    errors++;
                    $display("FAIL timeout_relock_count: got %0d expected %0d",
                             bus.relock_count, e);
                end
                if (rise_at >= 0) begin
                    checks++;
                    if (i - rise_at != RSTC + TMO) begin
                        errors++;
                        $display("FAIL timeout_period: got %0d expected %0d",
                                 i - rise_at, RSTC + TMO);
                    end
                end
                rise_at = i;
            end
            if (!bus.pll_rst && last && rise_at > 0) begin
                checks++;
                if (i - rise_at != RSTC) begin
                    errors++;
                    $display("FAIL timeout_pulse_width: got %0d expected %0d",
                             i - rise_at, RSTC);
                end
            end
            last = bus.pll_rst;
        end
        checks++;
        if (rises != 3) begin
            errors++;
            $display("FAIL timeout_repulse_count: got %0d expected 3", rises);
        end
        checks++;
        if (srst_bad != 0) begin
            errors++;
            $display("FAIL timeout_srst_held: got %0d expected 0", srst_bad);
        end
    endtask

    task automatic test_glitch();
        int lat = 0;
        int extra = 0;
        int e;
        apply_reset(1'b1);
        exp_q.push_back(0);
        rst_n = 1'b1;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            step();
            if (bus.pll_rst && i > RSTC) extra++;
            if (bus.sys_reset_n) lat = i;
            if (i == 10) bus.pll_locked = 1'b0;
            if (i == 11) bus.pll_locked = 1'b1;
        end
        checks++;
        if (lat < 11 + STB || lat > 11 + STB + 5) begin
            errors++;
            $display("FAIL glitch_release: got %0d expected 19..24", lat);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL glitch_no_repulse: got %0d expected 0", extra);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e)) begin
            errors++;
            $display("FAIL glitch_relock_count: got %0d expected %0d",
                     bus.relock_count, e);
        end
    endtask

    task automatic test_lock_loss();
        int k = 0;
        int pulses = 0;
        int at_lost = 0;
        int e;
        int run = 0;
        exp_q.push_back(1);
        bus.pll_locked = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.lock_lost) begin
                pulses++;
                at_lost = i;
            end
            if (k == 0 && !bus.sys_reset_n && bus.pll_rst) k = i;
        end
        checks++;
        if (k < 1 || k > SYN + 1) begin
            errors++;
            $display("FAIL loss_reset_delay: got %0d expected 1..%0d", k, SYN + 1);
        end
        checks++;
        if (pulses != 1 || at_lost != k) begin
            errors++;
            $display("FAIL loss_pulse: got %0d pulses at %0d expected 1 at %0d",
                     pulses, at_lost, k);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e)) begin
            errors++;
            $display("FAIL loss_relock_count: got %0d expected %0d",
                     bus.relock_count, e);
        end
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= 60 && run == 0; i++) begin
            step();
            if (bus.sys_reset_n) run = i;
        end
        checks++;
        if (run == 0) begin
            errors++;
            $display("FAIL loss_relock_run: got timeout expected RUN within 60");
        end
    endtask

    task automatic test_relock();
        int hi = 0;
        int srst1 = 0;
        int lost = 0;
        int run = 0;
        int e;
        exp_q.push_back(7);
        exp_q.push_back(3);
        bus.relock_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.pll_rst) hi++;
            if (bus.lock_lost) lost++;
            if (i == 1) srst1 = int'(bus.sys_reset_n);
            if (i == 1) bus.relock_req = 1'b0;
            if (i == 3) bus.relock_req = 1'b1;
            if (i == 4) bus.relock_req = 1'b0;
        end
        checks++;
        if (srst1 != 0) begin
            errors++;
            $display("FAIL relock_srst_next_edge: got %0d expected 0", srst1);
        end
        e = exp_q.pop_front();
        checks++;
        if (hi != e) begin
            errors++;
            $display("FAIL relock_restart_width: got %0d expected %0d", hi, e);
        end
        checks++;
        if (lost != 0) begin
            errors++;
            $display("FAIL relock_no_lock_lost: got %0d expected 0", lost);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e)) begin
            errors++;
            $display("FAIL relock_count: got %0d expected %0d",
                     bus.relock_count, e);
        end
        for (int i = 1; i <= 60 && run == 0; i++) begin
            step();
            if (bus.sys_reset_n) run = i;
        end
        checks++;
        if (run == 0) begin
            errors++;
            $display("FAIL relock_back_to_run: got timeout expected RUN within 60");
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int e;
        exp_q.push_back(4);
        exp_q.push_back(1);
        bus.pll_locked = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.lock_lost) pulses++;
            if (i == 2) bus.relock_req = 1'b1;
            if (i == 3) bus.relock_req = 1'b0;
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e)) begin
            errors++;
            $display("FAIL simul_relock_count: got %0d expected %0d",
                     bus.relock_count, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (pulses != e) begin
            errors++;
            $display("FAIL simul_lock_lost: got %0d expected %0d", pulses, e);
        end
    endtask

    task automatic test_saturation();
        int          prevc = 0;
        int          wrap = 0;
        int          e;
        logic        seen_hi = 1'b0;
        logic        found = 1'b0;
        logic [11:0] act;
        apply_reset(1'b0);
        exp_q.push_back(255);
        exp_q.push_back('h800);
        rst_n = 1'b1;
        for (int i = 1; i <= 300 * (RSTC + TMO) + 30; i++) begin
            step();
            if (int'(bus.relock_count) < prevc) wrap++;
            prevc = int'(bus.relock_count);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.relock_count !== 8'(e) || wrap != 0) begin
            errors++;
            $display("FAIL saturate: got %0d (wraps %0d) expected %0d",
                     bus.relock_count, wrap, e);
        end
        for (int i = 1; i <= 60 && !found; i++) begin
            step();
            if (bus.pll_rst) seen_hi = 1'b1;
            else if (seen_hi) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL saturate_wait_lock_entry: got timeout expected WAIT_LOCK");
        end
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        act = {bus.pll_rst, bus.sys_reset_n, bus.ready,
               bus.lock_lost, bus.relock_count};
        e = exp_q.pop_front();
        checks++;
        if (act !== 12'(e)) begin
            errors++;
            $display("FAIL async_reset_values: got %h expected %h", act, 12'(e));
        end
    endtask

    initial begin
        bus.pll_locked = 1'b1;
        bus.relock_req = 1'b0;
        test_reset();
        test_startup();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_relock();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
